// File: rtl/foc_isample_ctrl_pkg.sv
// Shared types and constants for the FOC current-sampling controller.
// Channel codes, phase-pair codes and the sector-to-pair decode live here.
package foc_isample_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StNext,
    StUpdate
  } fsm_state_e;

  localparam logic [1:0]  ChA       = 2'd0;
  localparam logic [1:0]  ChB       = 2'd1;
  localparam logic [1:0]  ChC       = 2'd2;

  localparam logic [3:0]  KkkBc     = 4'b0001;
  localparam logic [3:0]  KkkAc     = 4'b0010;
  localparam logic [3:0]  KkkAb     = 4'b0011;

  localparam logic [11:0] OffsetMid = 12'd2048;

  function automatic logic sector_valid(input logic [2:0] sector);
    return (sector != 3'd0) && (sector != 3'd7);
  endfunction

  function automatic logic [1:0] pair_first(input logic [2:0] sector);
    return (sector == 3'd1 || sector == 3'd6) ? ChB : ChA;
  endfunction

  function automatic logic [1:0] pair_second(input logic [2:0] sector);
    return (sector == 3'd4 || sector == 3'd5) ? ChB : ChC;
  endfunction

  function automatic logic [3:0] pair_kkk(input logic [2:0] sector);
    logic [3:0] kkk;
    case (sector)
      3'd1, 3'd6: kkk = KkkBc;
      3'd2, 3'd3: kkk = KkkAc;
      default:    kkk = KkkAb;
    endcase
    return kkk;
  endfunction

endpackage

// File: rtl/foc_offset_acc.sv
// Per-channel offset calibration: sums 2^CAL_LOG2 complete A/B/C triplets
// and publishes the truncated mean of each channel as its offset.
module foc_offset_acc
  import foc_isample_ctrl_pkg::*;
#(
  parameter int unsigned CAL_LOG2 = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clr,
  input  logic            i_add,
  input  logic [2:0][11:0] i_code,
  output logic [2:0][11:0] o_offset,
  output logic            o_done
);

  localparam int unsigned AccW = 12 + CAL_LOG2;
  localparam int unsigned CntW = CAL_LOG2 + 1;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << CAL_LOG2) - 1);

  logic [2:0][AccW-1:0] r_acc;
  logic [CntW-1:0]      r_cnt;
  logic                 r_done;
  logic [2:0][11:0]     r_off;
  logic [2:0][AccW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int c = 0; c < 3; c++) begin
      w_sum[c] = r_acc[c] + AccW'(i_code[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_off  <= {3{OffsetMid}};
    end else if (i_clr) begin
      r_acc  <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
      r_off  <= {3{OffsetMid}};
    end else if (i_add && !r_done) begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CntLast) begin
        r_done <= 1'b1;
        for (int c = 0; c < 3; c++) begin
          r_off[c] <= w_sum[c][AccW-1:CAL_LOG2];
        end
      end
    end
  end

  assign o_offset = r_off;
  assign o_done   = r_done;

endmodule

// File: rtl/foc_isample_ctrl.sv
// Sequences two-phase current conversions per PWM trigger, removes per-channel
// offsets, and runs A/B/C offset calibration until offsets are valid.
module foc_isample_ctrl
  import foc_isample_ctrl_pkg::*;
#(
  parameter int unsigned CAL_LOG2    = 6,
  parameter int unsigned ADC_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_trig_i,
  input  logic [2:0]  sector_i,
  input  logic        cal_start_i,
  output logic        adc_req_o,
  output logic [1:0]  adc_ch_o,
  input  logic        adc_done_i,
  input  logic [11:0] adc_dat_i,
  output logic [31:0] dat_o,
  output logic [31:0] dat3_o,
  output logic [3:0]  kkk_o,
  output logic        smp_vld_o,
  output logic        cal_done_o,
  output logic        busy_o,
  output logic        ovr_o,
  output logic        err_o
);

  localparam int unsigned TmrW = $clog2(ADC_TIMEOUT + 1);
  localparam logic [TmrW-1:0] TmrLast = TmrW'(ADC_TIMEOUT - 1);

  fsm_state_e       r_state;
  logic             r_cal_mode;
  logic             r_cal_pend;
  logic [1:0]       r_ch_first;
  logic [1:0]       r_ch_second;
  logic [3:0]       r_seq_kkk;
  logic [1:0]       r_idx;
  logic [1:0][11:0] r_code;
  logic [TmrW-1:0]  r_tmr;
  logic             r_adc_req;
  logic [1:0]       r_adc_ch;
  logic [31:0]      r_dat;
  logic [31:0]      r_dat3;
  logic [3:0]       r_kkk;
  logic             r_smp_vld;
  logic             r_ovr;
  logic             r_err;

  logic             w_clr;
  logic             w_cal_now;
  logic             w_last;
  logic             w_add;
  logic [2:0][11:0] w_codes;
  logic [2:0][11:0] w_offset;
  logic             w_cal_done;
  logic [11:0]      w_off_first;
  logic [11:0]      w_off_second;

  // A pending or fresh calibration request wins over a coincident trigger.
  assign w_clr        = (r_state == StIdle) && (cal_start_i || r_cal_pend);
  assign w_cal_now    = !w_cal_done || w_clr;
  assign w_last       = r_cal_mode ? (r_idx == 2'd2) : (r_idx == 2'd1);
  assign w_add        = (r_state == StWait) && adc_done_i && w_last && r_cal_mode;
  assign w_codes      = {adc_dat_i, r_code[1], r_code[0]};
  assign w_off_first  = w_offset[r_ch_first];
  assign w_off_second = w_offset[r_ch_second];

  foc_offset_acc #(
    .CAL_LOG2 (CAL_LOG2)
  ) u_offset_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_clr),
    .i_add    (w_add),
    .i_code   (w_codes),
    .o_offset (w_offset),
    .o_done   (w_cal_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cal_mode  <= 1'b0;
      r_cal_pend  <= 1'b0;
      r_ch_first  <= ChA;
      r_ch_second <= ChA;
      r_seq_kkk   <= '0;
      r_idx       <= '0;
      r_code      <= '0;
      r_tmr       <= '0;
      r_adc_req   <= 1'b0;
      r_adc_ch    <= ChA;
      r_dat       <= '0;
      r_dat3      <= '0;
      r_kkk       <= '0;
      r_smp_vld   <= 1'b0;
      r_ovr       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_smp_vld <= 1'b0;
      r_ovr     <= 1'b0;
      r_err     <= 1'b0;

      if (cal_start_i && r_state != StIdle) begin
        r_cal_pend <= 1'b1;
      end else if (w_clr) begin
        r_cal_pend <= 1'b0;
      end

      if (pwm_trig_i && r_state != StIdle) begin
        r_ovr <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (pwm_trig_i) begin
            if (!sector_valid(sector_i)) begin
              r_err <= 1'b1;
            end else begin
              r_cal_mode  <= w_cal_now;
              r_ch_first  <= w_cal_now ? ChA : pair_first(sector_i);
              r_ch_second <= pair_second(sector_i);
              r_seq_kkk   <= pair_kkk(sector_i);
              r_adc_ch    <= w_cal_now ? ChA : pair_first(sector_i);
              r_adc_req   <= 1'b1;
              r_idx       <= '0;
              r_state     <= StReq;
            end
          end
        end
        StReq: begin
          r_tmr   <= '0;
          r_state <= StWait;
        end
        StWait: begin
          if (adc_done_i) begin
            r_adc_req <= 1'b0;
            if (!r_idx[1]) begin
              r_code[r_idx[0]] <= adc_dat_i;
            end
            if (w_last) begin
              r_state <= StUpdate;
              if (!r_cal_mode) begin
                r_dat     <= {20'h0, r_code[0]} - {20'h0, w_off_first};
                r_dat3    <= {20'h0, adc_dat_i} - {20'h0, w_off_second};
                r_kkk     <= r_seq_kkk;
                r_smp_vld <= 1'b1;
              end
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= StNext;
            end
          end else if (r_tmr == TmrLast) begin
            r_adc_req <= 1'b0;
            r_err     <= 1'b1;
            r_state   <= StIdle;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        StNext: begin
          if (r_cal_mode) begin
            r_adc_ch <= (r_idx == 2'd1) ? ChB : ChC;
          end else begin
            r_adc_ch <= r_ch_second;
          end
          r_adc_req <= 1'b1;
          r_state   <= StReq;
        end
        StUpdate: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign adc_req_o  = r_adc_req;
  assign adc_ch_o   = r_adc_ch;
  assign dat_o      = r_dat;
  assign dat3_o     = r_dat3;
  assign kkk_o      = r_kkk;
  assign smp_vld_o  = r_smp_vld;
  assign cal_done_o = w_cal_done;
  assign busy_o     = (r_state != StIdle);
  assign ovr_o      = r_ovr;
  assign err_o      = r_err;

endmodule

// File: tb/tb_foc_isample_ctrl.sv
// Directed bench for foc_isample_ctrl: calibration, sector pairs, timeout,
// invalid sector, overrun, recalibration and mid-sequence reset.
module tb_foc_isample_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_trig_i = 1'b0;
  logic [2:0]  sector_i = '0;
  logic        cal_start_i = 1'b0;
  logic        adc_req_o;
  logic [1:0]  adc_ch_o;
  logic        adc_done_i = 1'b0;
  logic [11:0] adc_dat_i = '0;
  logic [31:0] dat_o;
  logic [31:0] dat3_o;
  logic [3:0]  kkk_o;
  logic        smp_vld_o;
  logic        cal_done_o;
  logic        busy_o;
  logic        ovr_o;
  logic        err_o;

  foc_isample_ctrl #(
    .CAL_LOG2    (6),
    .ADC_TIMEOUT (255)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwm_trig_i  (pwm_trig_i),
    .sector_i    (sector_i),
    .cal_start_i (cal_start_i),
    .adc_req_o   (adc_req_o),
    .adc_ch_o    (adc_ch_o),
    .adc_done_i  (adc_done_i),
    .adc_dat_i   (adc_dat_i),
    .dat_o       (dat_o),
    .dat3_o      (dat3_o),
    .kkk_o       (kkk_o),
    .smp_vld_o   (smp_vld_o),
    .cal_done_o  (cal_done_o),
    .busy_o      (busy_o),
    .ovr_o       (ovr_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vld_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [1:0]  seen_ch [3];
  logic [11:0] code_a, code_b, code_c;

  always @(negedge clk) begin
    if (smp_vld_o) vld_cnt++;
    if (err_o) err_cnt++;
    if (ovr_o) ovr_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic trigger(input logic [2:0] s);
    sector_i   = s;
    pwm_trig_i = 1'b1;
    step();
    pwm_trig_i = 1'b0;
  endtask

  // Model ADC: answers each request one cycle into WAIT with the channel's code.
  task automatic serve(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!adc_req_o && t < 20) begin
        step();
        t++;
      end
      if (!adc_req_o) begin
        check("adc_req_seen", 32'(adc_req_o), 32'd1);
        return;
      end
      seen_ch[k] = adc_ch_o;
      step();
      adc_done_i = 1'b1;
      adc_dat_i  = (adc_ch_o == 2'd0) ? code_a : (adc_ch_o == 2'd1) ? code_b : code_c;
      step();
      adc_done_i = 1'b0;
    end
  endtask

  task automatic wait_drop(output int t);
    t = 0;
    while (adc_req_o && t < 400) begin
      step();
      t++;
    end
  endtask

  initial begin
    int v, e, o, t;
    code_a = '0;
    code_b = '0;
    code_c = '0;
    repeat (2) step();
    check("rst_adc_req", 32'(adc_req_o), 32'd0);
    check("rst_adc_ch", 32'(adc_ch_o), 32'd0);
    check("rst_dat", dat_o, 32'd0);
    check("rst_dat3", dat3_o, 32'd0);
    check("rst_kkk", 32'(kkk_o), 32'd0);
    check("rst_vld", 32'(smp_vld_o), 32'd0);
    check("rst_cal_done", 32'(cal_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err_ovr", 32'({err_o, ovr_o}), 32'd0);
    rst_n = 1'b1;
    step();

    // Initial calibration.
    code_a = 12'd2050;
    code_b = 12'd2040;
    code_c = 12'd2060;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("cal_done_before_last", 32'(cal_done_o), 32'd0);
      trigger(3'd1);
      serve(3);
      if (i == 0) begin
        check("cal_ch0", 32'(seen_ch[0]), 32'd0);
        check("cal_ch1", 32'(seen_ch[1]), 32'd1);
        check("cal_ch2", 32'(seen_ch[2]), 32'd2);
      end
      step();
    end
    check("cal_done", 32'(cal_done_o), 32'd1);
    check("cal_no_vld", 32'(vld_cnt), 32'd0);

    // Sector 2: A then C.
    code_a = 12'd2100;
    code_c = 12'd2000;
    v = vld_cnt;
    trigger(3'd2);
    serve(2);
    check("s2_ch_first", 32'(seen_ch[0]), 32'd0);
    check("s2_ch_second", 32'(seen_ch[1]), 32'd2);
    check("s2_vld_latency", 32'(smp_vld_o), 32'd1);
    check("s2_dat", dat_o, 32'd50);
    check("s2_dat3", dat3_o, 32'hFFFF_FFC4);
    check("s2_kkk", 32'(kkk_o), 32'b0010);
    step();
    check("s2_vld_drop", 32'(smp_vld_o), 32'd0);
    check("s2_idle", 32'(busy_o), 32'd0);
    check("s2_dat_hold", dat_o, 32'd50);
    check("s2_vld_once", 32'(vld_cnt), 32'(v + 1));

    // Sector 5: A then B.
    code_b = 12'd2000;
    trigger(3'd5);
    serve(2);
    check("s5_ch_first", 32'(seen_ch[0]), 32'd0);
    check("s5_ch_second", 32'(seen_ch[1]), 32'd1);
    check("s5_dat", dat_o, 32'd50);
    check("s5_dat3", dat3_o, 32'hFFFF_FFD8);
    check("s5_kkk", 32'(kkk_o), 32'b0011);
    step();

    // Sector 6: B then C.
    code_c = 12'd2100;
    trigger(3'd6);
    serve(2);
    check("s6_ch_first", 32'(seen_ch[0]), 32'd1);
    check("s6_ch_second", 32'(seen_ch[1]), 32'd2);
    check("s6_dat", dat_o, 32'hFFFF_FFD8);
    check("s6_dat3", dat3_o, 32'd40);
    check("s6_kkk", 32'(kkk_o), 32'b0001);
    step();

    // ADC timeout: request high for REQ plus 255 WAIT cycles.
    e = err_cnt;
    v = vld_cnt;
    trigger(3'd3);
    wait_drop(t);
    check("tmo_req_cycles", 32'(t), 32'd256);
    check("tmo_err", 32'(err_o), 32'd1);
    check("tmo_req_low", 32'(adc_req_o), 32'd0);
    check("tmo_idle", 32'(busy_o), 32'd0);
    check("tmo_dat_hold", dat_o, 32'hFFFF_FFD8);
    check("tmo_kkk_hold", 32'(kkk_o), 32'b0001);
    step();
    check("tmo_err_once", 32'(err_cnt), 32'(e + 1));

    // Stray done outside WAIT is ignored.
    adc_done_i = 1'b1;
    step();
    adc_done_i = 1'b0;
    step();
    check("stray_idle", 32'(busy_o), 32'd0);
    check("stray_no_vld", 32'(vld_cnt), 32'(v));

    // Invalid sectors.
    trigger(3'd7);
    check("s7_err", 32'(err_o), 32'd1);
    check("s7_no_req", 32'(adc_req_o), 32'd0);
    check("s7_idle", 32'(busy_o), 32'd0);
    step();
    trigger(3'd0);
    check("s0_err", 32'(err_o), 32'd1);
    check("s0_idle", 32'(busy_o), 32'd0);
    step();

    // Overrun while busy.
    code_a = 12'd2100;
    code_b = 12'd2000;
    o = ovr_cnt;
    trigger(3'd4);
    pwm_trig_i = 1'b1;
    step();
    pwm_trig_i = 1'b0;
    check("ovr_pulse", 32'(ovr_o), 32'd1);
    serve(2);
    check("ovr_vld", 32'(smp_vld_o), 32'd1);
    check("ovr_kkk", 32'(kkk_o), 32'b0011);
    check("ovr_dat", dat_o, 32'd50);
    step();
    check("ovr_once", 32'(ovr_cnt), 32'(o + 1));

    // Calibration request while busy is deferred.
    code_b = 12'd2000;
    code_c = 12'd2100;
    trigger(3'd6);
    cal_start_i = 1'b1;
    step();
    cal_start_i = 1'b0;
    serve(2);
    check("calreq_seq_vld", 32'(smp_vld_o), 32'd1);
    check("calreq_seq_dat", dat_o, 32'hFFFF_FFD8);
    check("calreq_still_done", 32'(cal_done_o), 32'd1);
    step();
    step();
    check("calreq_cleared", 32'(cal_done_o), 32'd0);

    // Recalibration with a timed-out trigger that must not count.
    code_b = 12'd3000;
    code_c = 12'd1003;
    v = vld_cnt;
    for (int i = 0; i < 64; i++) begin
      if (i == 10) begin
        trigger(3'd1);
        wait_drop(t);
        check("recal_tmo_cycles", 32'(t), 32'd256);
        step();
      end
      code_a = (i % 2 == 1) ? 12'd1001 : 12'd1000;
      if (i == 63) check("recal_done_before_last", 32'(cal_done_o), 32'd0);
      trigger(3'd1);
      serve(3);
      step();
    end
    check("recal_done", 32'(cal_done_o), 32'd1);
    check("recal_no_vld", 32'(vld_cnt), 32'(v));

    // New offsets: A=1000 (truncated mean), B=3000, C=1003.
    code_a = 12'd1100;
    code_c = 12'd1003;
    trigger(3'd3);
    serve(2);
    check("s3_dat", dat_o, 32'd100);
    check("s3_dat3", dat3_o, 32'd0);
    check("s3_kkk", 32'(kkk_o), 32'b0010);
    step();
    code_b = 12'd2990;
    trigger(3'd4);
    serve(2);
    check("s4_dat3", dat3_o, 32'hFFFF_FFF6);
    step();

    // Coincident cal_start and trigger: calibration conversion wins.
    v = vld_cnt;
    cal_start_i = 1'b1;
    trigger(3'd2);
    cal_start_i = 1'b0;
    serve(3);
    check("sim_ch0", 32'(seen_ch[0]), 32'd0);
    check("sim_ch1", 32'(seen_ch[1]), 32'd1);
    check("sim_ch2", 32'(seen_ch[2]), 32'd2);
    check("sim_cal_done", 32'(cal_done_o), 32'd0);
    step();
    check("sim_no_vld", 32'(vld_cnt), 32'(v));

    // Reset during WAIT.
    trigger(3'd1);
    step();
    check("mid_busy", 32'(busy_o), 32'd1);
    check("mid_req", 32'(adc_req_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", 32'(adc_req_o), 32'd0);
    check("mid_rst_dat", dat_o, 32'd0);
    check("mid_rst_dat3", dat3_o, 32'd0);
    check("mid_rst_kkk", 32'(kkk_o), 32'd0);
    check("mid_rst_cal", 32'(cal_done_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/foc_isample_ctrl.md
FOC_ISAMPLE_CTRL -- requirements
Module: foc_isample_ctrl

Interface
REQ-001 Parameter CAL_LOG2, default 6, SHALL set calibration length to 2^CAL_LOG2 triggers.
REQ-002 Parameter ADC_TIMEOUT, default 255, SHALL set max cycles from adc_req_o rise to adc_done_i.
REQ-003 Ports SHALL be:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- pwm_trig_i  in  1  one-cycle PWM-centre sample trigger.
- sector_i  in  3  commutation sector, valid 1..6.
- cal_start_i  in  1  one-cycle request to re-run offset calibration.
- adc_req_o  out  1  conversion request to ADC.
- adc_ch_o  out  2  ADC channel (0=A, 1=B, 2=C).
- adc_done_i  in  1  conversion complete, one cycle, data valid same cycle.
- adc_dat_i  in  12  unsigned ADC code.
- dat_o  out  32  first measured phase, offset-removed, two's complement.
- dat3_o  out  32  second measured phase, offset-removed, two's complement.
- kkk_o  out  4  phase-pair code for the current datapath.
- smp_vld_o  out  1  one-cycle pulse, dat_o/dat3_o/kkk_o updated.
- cal_done_o  out  1  offsets valid.
- busy_o  out  1  sequence in progress.
- ovr_o  out  1  one-cycle pulse, trigger dropped.
- err_o  out  1  one-cycle pulse, ADC timeout or invalid sector.

Function
REQ-004 FSM states SHALL be IDLE, REQ, WAIT, NEXT, UPDATE; busy_o = (state != IDLE).
REQ-005 In IDLE, pwm_trig_i SHALL capture sector_i and start a sequence next cycle; trigger while busy SHALL be dropped with ovr_o pulse.
REQ-006 Normal mode channel pairs (first, second, kkk_o): sectors 1,6 -> B,C,4'b0001; 2,3 -> A,C,4'b0010; 4,5 -> A,B,4'b0011.
REQ-007 Sector 0 or 7 at trigger SHALL pulse err_o, remain IDLE, leave outputs unchanged.
REQ-008 Calibration mode SHALL convert A, B, C in order per trigger and not assert smp_vld_o.
REQ-009 adc_req_o SHALL rise in REQ, stay high with adc_ch_o stable until the cycle adc_done_i is high, and drop the following cycle.
REQ-010 adc_dat_i SHALL be captured in the cycle adc_done_i is high; adc_done_i outside WAIT SHALL be ignored.
REQ-011 WAIT cycle counter reaching ADC_TIMEOUT without adc_done_i SHALL drop adc_req_o, pulse err_o, return to IDLE, no smp_vld_o, no accumulator update.
REQ-012 Outputs SHALL be dat = {20'h0,code} - offset, 32-bit wrap; dat_o/dat3_o/kkk_o registered in UPDATE, smp_vld_o high same cycle, values held until next UPDATE.
REQ-013 Latency SHALL be one cycle from the second capturing adc_done_i to smp_vld_o.
REQ-014 Calibration SHALL sum 2^CAL_LOG2 codes per channel in (12+CAL_LOG2)-bit accumulators; at completion offset = sum >> CAL_LOG2 (truncate), cal_done_o set.
REQ-015 Before cal_done_o, triggers SHALL run calibration only; offsets read 12'd2048.
REQ-016 cal_start_i in IDLE SHALL clear accumulators and cal_done_o next cycle; while busy it SHALL be latched and applied on return to IDLE; simultaneous with pwm_trig_i in IDLE, cal_start_i SHALL win and the trigger SHALL start a calibration conversion.
REQ-017 A timed-out calibration trigger SHALL not count toward 2^CAL_LOG2.

Reset
REQ-018 rst_n low SHALL force IDLE, adc_req_o=0, adc_ch_o=0, dat_o=dat3_o=0, kkk_o=0, all pulses 0, cal_done_o=0, offsets 12'd2048, accumulators 0, pending cal 0.
REQ-019 After reset release calibration SHALL be pending automatically; reset mid-sequence SHALL abandon the conversion with no output update.

Structure
REQ-020 A shared package SHALL hold the FSM state enum, channel codes A/B/C, and kkk code constants 4'b0001/0010/0011.
REQ-021 One sub-module foc_offset_acc (per-channel accumulator, count, divide) SHALL be instantiated once, indexed by channel.

Verification
REQ-022 Reset, 64 triggers, ADC returns 2050/2040/2060 for A/B/C -> cal_done_o=1, offsets 2050/2040/2060, no smp_vld_o.
REQ-023 After cal, sector 2, codes A=2100, C=2000 -> adc_ch_o 0 then 2, smp_vld_o one cycle after second done, dat_o=50, dat3_o=0xFFFFFFC4, kkk_o=4'b0010.
REQ-024 Sector 5 and sector 6 triggers -> kkk_o 4'b0011 (A,B) and 4'b0001 (B,C), correct channel order.
REQ-025 adc_done_i withheld 255 cycles -> err_o pulse, adc_req_o low, IDLE, outputs unchanged; sector 7 trigger -> err_o, no adc_req_o.
REQ-026 pwm_trig_i while busy -> ovr_o pulse, sequence completes normally; cal_start_i while busy -> current sequence completes, then cal_done_o=0 and next 64 triggers recalibrate.
REQ-027 rst_n low during WAIT -> adc_req_o=0 immediately, outputs zero, cal_done_o=0.
